// File: rtl/crc_encoding.sv
// Transmit-side USB packet serializer: sends PID, ~PID, payload and the complemented
// CRC5 (token) or CRC16 (data) MSB-first, one bit per valid/ready transfer.
module crc_encoding #(
   parameter int TOKEN_BITS = 11,
   parameter int DATA_BITS  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  pid,
   input  logic [63:0] payload,
   input  logic        pktInAvail,
   output logic        readyIn,
   output logic        bitOut,
   output logic        bitOutAvail,
   input  logic        bitOutReady,
   output logic        pktDone
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PIDS    = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CRC     = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_HS   = 2'd0,
      K_TOK  = 2'd1,
      K_DATA = 2'd2
   } kind_t;

   localparam int TOK_PAD  = 64 - TOKEN_BITS;
   localparam int DATA_PAD = 64 - DATA_BITS;
   localparam logic [6:0] PID_END  = 7'd8;
   localparam logic [6:0] TOK_END  = 7'(8 + TOKEN_BITS);
   localparam logic [6:0] DATA_END = 7'(8 + DATA_BITS);
   localparam logic [6:0] TOK_LEN  = 7'(8 + TOKEN_BITS + 5);
   localparam logic [6:0] DATA_LEN = 7'(8 + DATA_BITS + 16);

   function automatic kind_t decode_kind(input logic [3:0] p);
      kind_t k;
      if (p[3:1] == 3'b100) begin
         k = K_TOK;
      end else if (p == 4'b1100) begin
         k = K_DATA;
      end else begin
         k = K_HS;
      end
      return k;
   endfunction

   // Token CRC lives in bits [4:0]; upper bits are don't-care for tokens.
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din,
                                            input logic is_tok);
      logic [15:0] nxt;
      logic        fb;
      if (is_tok) begin
         fb  = crc[4] ^ din;
         nxt = {11'd0, crc[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
      end else begin
         fb  = crc[15] ^ din;
         nxt = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return nxt;
   endfunction

   state_t      r_state, w_state_n;
   kind_t       r_kind, w_kind_n;
   logic [70:0] r_sh, w_sh_n;
   logic        r_bit, w_bit_n;
   logic        r_avail, w_avail_n;
   logic        r_ready, w_ready_n;
   logic        r_done, w_done_n;
   logic [6:0]  r_cnt, w_cnt_n;
   logic [15:0] r_crc, w_crc_n;

   logic        w_xfer;
   logic        w_is_tok;
   logic [6:0]  w_cnt_inc;
   logic [6:0]  w_pay_end;
   logic [6:0]  w_pkt_len;
   logic [15:0] w_crc_upd;
   logic [63:0] w_field;
   kind_t       w_in_kind;

   assign w_xfer    = r_avail & bitOutReady;
   assign w_is_tok  = (r_kind == K_TOK);
   assign w_cnt_inc = r_cnt + 7'd1;
   assign w_pay_end = w_is_tok ? TOK_END : DATA_END;
   assign w_pkt_len = w_is_tok ? TOK_LEN : DATA_LEN;
   assign w_crc_upd = crc_step(r_crc, r_bit, w_is_tok);
   assign w_in_kind = decode_kind(pid);
   assign w_field   = (w_in_kind == K_TOK) ? (payload << TOK_PAD) : (payload << DATA_PAD);

   // r_bit always holds the bit on the wire; r_sh holds the rest of PID/payload.
   always_comb begin
      w_state_n = r_state;
      w_kind_n  = r_kind;
      w_sh_n    = r_sh;
      w_bit_n   = r_bit;
      w_avail_n = r_avail;
      w_ready_n = r_ready;
      w_done_n  = 1'b0;
      w_cnt_n   = r_cnt;
      w_crc_n   = r_crc;
      case (r_state)
         S_IDLE: begin
            if (pktInAvail && r_ready) begin
               w_state_n = S_PIDS;
               w_kind_n  = w_in_kind;
               w_sh_n    = {pid[2:0], ~pid, w_field};
               w_bit_n   = pid[3];
               w_avail_n = 1'b1;
               w_ready_n = 1'b0;
               w_cnt_n   = 7'd0;
               w_crc_n   = 16'hFFFF;
            end else begin
               w_avail_n = 1'b0;
            end
         end
         S_PIDS: begin
            if (w_xfer) begin
               w_cnt_n = w_cnt_inc;
               if ((w_cnt_inc == PID_END) && (r_kind == K_HS)) begin
                  w_state_n = S_IDLE;
                  w_bit_n   = 1'b0;
                  w_avail_n = 1'b0;
                  w_ready_n = 1'b1;
                  w_done_n  = 1'b1;
                  w_cnt_n   = 7'd0;
               end else begin
                  if (w_cnt_inc == PID_END) begin
                     w_state_n = S_PAYLOAD;
                  end else begin
                     w_state_n = S_PIDS;
                  end
                  w_bit_n = r_sh[70];
                  w_sh_n  = {r_sh[69:0], 1'b0};
               end
            end else begin
               w_state_n = S_PIDS;
            end
         end
         S_PAYLOAD: begin
            if (w_xfer) begin
               w_cnt_n = w_cnt_inc;
               w_crc_n = w_crc_upd;
               if (w_cnt_inc == w_pay_end) begin
                  w_state_n = S_CRC;
                  w_bit_n   = w_is_tok ? ~w_crc_upd[4] : ~w_crc_upd[15];
               end else begin
                  w_bit_n = r_sh[70];
                  w_sh_n  = {r_sh[69:0], 1'b0};
               end
            end else begin
               w_state_n = S_PAYLOAD;
            end
         end
         S_CRC: begin
            if (w_xfer) begin
               w_cnt_n = w_cnt_inc;
               if (w_cnt_inc == w_pkt_len) begin
                  w_state_n = S_IDLE;
                  w_bit_n   = 1'b0;
                  w_avail_n = 1'b0;
                  w_ready_n = 1'b1;
                  w_done_n  = 1'b1;
                  w_cnt_n   = 7'd0;
               end else begin
                  w_bit_n = w_is_tok ? ~r_crc[3] : ~r_crc[14];
                  w_crc_n = {r_crc[14:0], 1'b0};
               end
            end else begin
               w_state_n = S_CRC;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_bit_n   = 1'b0;
            w_avail_n = 1'b0;
            w_ready_n = 1'b1;
            w_cnt_n   = 7'd0;
         end
      endcase
   end

   // State and output registers; reset abandons any packet in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_kind  <= K_HS;
         r_sh    <= 71'd0;
         r_bit   <= 1'b0;
         r_avail <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_cnt   <= 7'd0;
         r_crc   <= 16'hFFFF;
      end else begin
         r_state <= w_state_n;
         r_kind  <= w_kind_n;
         r_sh    <= w_sh_n;
         r_bit   <= w_bit_n;
         r_avail <= w_avail_n;
         r_ready <= w_ready_n;
         r_done  <= w_done_n;
         r_cnt   <= w_cnt_n;
         r_crc   <= w_crc_n;
      end
   end

   assign readyIn     = r_ready;
   assign bitOut      = r_bit;
   assign bitOutAvail = r_avail;
   assign pktDone     = r_done;

endmodule

// File: tb/tb_crc_encoding.sv
// Scoreboard bench for crc_encoding: the driver queues expected bits per packet,
// a negedge monitor pops and compares every transferred bit, pktDone and CRC residue.
module tb_crc_encoding;

   typedef struct {
      logic b;
      logic last;
      int   kind;
      int   pos;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  pid;
   logic [63:0] payload;
   logic        pktInAvail;
   logic        readyIn;
   logic        bitOut;
   logic        bitOutAvail;
   logic        bitOutReady;
   logic        pktDone;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_xfer   = 0;

   crc_encoding dut (
      .clk         (clk),
      .rst         (rst),
      .pid         (pid),
      .payload     (payload),
      .pktInAvail  (pktInAvail),
      .readyIn     (readyIn),
      .bitOut      (bitOut),
      .bitOutAvail (bitOutAvail),
      .bitOutReady (bitOutReady),
      .pktDone     (pktDone)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] c, input logic d, input logic tok);
      logic fb;
      if (tok) begin
         fb = c[4] ^ d;
         return {11'd0, c[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
      end
      fb = c[15] ^ d;
      return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   function automatic logic [15:0] crc16_ref(input logic [63:0] d);
      logic [15:0] c = 16'hFFFF;
      for (int i = 63; i >= 0; i--) c = step(c, d[i], 1'b0);
      return c;
   endfunction

   task automatic push_stream(input int kind, input logic [87:0] bits, input int len);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.b    = bits[87-i];
         e.last = (i == len - 1);
         e.kind = kind;
         e.pos  = i;
         q.push_back(e);
      end
   endtask

   task automatic push_data(input logic [63:0] d);
      logic [15:0] c;
      c = crc16_ref(d);
      push_stream(2, {4'b1100, 4'b0011, d, ~c}, 88);
   endtask

   task automatic start_pkt(input logic [3:0] p, input logic [63:0] d, input bit hold);
      int w = 0;
      while (!readyIn && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check("readyIn_before_accept", readyIn, 1);
      pid = p;
      payload = d;
      pktInAvail = 1'b1;
      @(posedge clk); #1;
      if (!hold) pktInAvail = 1'b0;
      check("first_bit_avail", bitOutAvail, 1);
      check("readyIn_drop", readyIn, 0);
   endtask

   task automatic wait_done(input int exp_len, input int stall_at, input int stall_len);
      int stalled = 0;
      int base = n_xfer;
      int got = -1;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         if (pktDone) begin
            got = c;
            break;
         end
         if (stall_len > 0 && (n_xfer - base) == stall_at && stalled < stall_len) begin
            bitOutReady = 1'b0;
            stalled++;
         end else begin
            bitOutReady = 1'b1;
         end
      end
      bitOutReady = 1'b1;
      check("pktDone_latency", got, exp_len + stall_len);
      check("readyIn_at_done", readyIn, 1);
   endtask

   // Monitor: a transfer seen at negedge completes at the following posedge.
   initial begin : monitor
      logic        prev_av = 1'b0;
      logic        prev_rd = 1'b1;
      logic        prev_bit = 1'b0;
      logic        exp_done = 1'b0;
      logic [15:0] res = 16'hFFFF;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_av  = 1'b0;
            exp_done = 1'b0;
         end else begin
            check("pktDone", pktDone, exp_done);
            exp_done = 1'b0;
            if (prev_av && !prev_rd) begin
               check("stall_hold_avail", bitOutAvail, 1);
               check("stall_hold_bit", bitOut, prev_bit);
            end
            if (bitOutAvail && bitOutReady) begin
               if (q.size() == 0) begin
                  check("unexpected_bit_avail", bitOutAvail, 0);
               end else begin
                  e = q.pop_front();
                  n_xfer++;
                  check($sformatf("bit_k%0d_p%0d", e.kind, e.pos), bitOut, e.b);
                  if (e.pos == 8) res = 16'hFFFF;
                  if (e.pos >= 8) res = step(res, bitOut, e.kind == 1);
                  if (e.last) begin
                     exp_done = 1'b1;
                     if (e.kind == 1) check("residue5", res[4:0], 5'b01100);
                     else if (e.kind == 2) check("residue16", res, 16'h800D);
                  end
               end
            end
            prev_av  = bitOutAvail;
            prev_rd  = bitOutReady;
            prev_bit = bitOut;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int base;
      rst = 1'b1;
      pid = 4'd0;
      payload = 64'd0;
      pktInAvail = 1'b0;
      bitOutReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_readyIn", readyIn, 1);
      check("rst_bitOutAvail", bitOutAvail, 0);
      check("rst_bitOut", bitOut, 0);
      check("rst_pktDone", pktDone, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: handshake
      push_stream(0, {8'b0010_1101, 80'd0}, 8);
      start_pkt(4'b0010, 64'd0, 1'b0);
      wait_done(8, 0, 0);

      // 2: token, zero payload
      push_stream(1, {24'b1000_0111_00000000000_01000, 64'd0}, 24);
      start_pkt(4'b1000, 64'd0, 1'b0);
      wait_done(24, 0, 0);

      // 3: data
      push_data(64'h0123_4567_89AB_CDEF);
      start_pkt(4'b1100, 64'h0123_4567_89AB_CDEF, 1'b0);
      wait_done(88, 0, 0);

      // 4: token with a 3-cycle stall at payload bit 5
      push_stream(1, {24'b1000_0111_00000000000_01000, 64'd0}, 24);
      start_pkt(4'b1000, 64'd0, 1'b0);
      wait_done(24, 13, 3);

      // 5: reset at data bit 40, then a fresh data packet
      push_data(64'h0123_4567_89AB_CDEF);
      start_pkt(4'b1100, 64'h0123_4567_89AB_CDEF, 1'b0);
      base = n_xfer;
      for (int c = 0; c < 200 && (n_xfer - base) < 40; c++) begin
         @(posedge clk); #1;
      end
      check("reached_bit40", n_xfer - base, 40);
      rst = 1'b1;
      q.delete();
      #1;
      check("midrst_bitOutAvail", bitOutAvail, 0);
      check("midrst_readyIn", readyIn, 1);
      check("midrst_pktDone", pktDone, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      push_data(64'hFFFF_0000_A5A5_5A5A);
      start_pkt(4'b1100, 64'hFFFF_0000_A5A5_5A5A, 1'b0);
      wait_done(88, 0, 0);

      // 6: back-to-back, second request held through the busy period
      push_stream(1, {24'b1000_0111_00000000000_01000, 64'd0}, 24);
      push_stream(0, {8'b1010_0101, 80'd0}, 8);
      start_pkt(4'b1000, 64'd0, 1'b1);
      pid = 4'b1010;
      payload = 64'hDEAD_BEEF_0000_0001;
      wait_done(24, 0, 0);
      @(posedge clk); #1;
      pktInAvail = 1'b0;
      check("b2b_no_gap_avail", bitOutAvail, 1);
      check("b2b_readyIn_drop", readyIn, 0);
      wait_done(8, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", q.size(), 0);
      check("idle_bitOutAvail", bitOutAvail, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
